mem_access_stage: RTL

//  MEM pipeline stage: consumes the EXE/MEM register outputs and performs byte/half/word

---
 rtl/mem_access_stage.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: byte/half/word loads and stores on a req/ack bus, registers MEM/WB results (1 cycle + bus wait cycles).
// Holds the pipeline via o_stall while an access is outstanding; aborts after MAX_WAIT unacked cycles.
module mem_access_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_mem_mem2reg,
  input  logic        i_mem_wmem,
  input  logic        i_mem_wreg,
  input  logic        i_mem_lsb,
  input  logic        i_mem_lsh,
  input  logic        i_mem_loadsignext,
  input  logic [4:0]  i_mem_rd,
  input  logic [31:0] i_mem_data,
  input  logic [31:0] i_mem_dmem,
  output logic        o_dbus_req,
  output logic        o_dbus_we,
  output logic [31:0] o_dbus_addr,
  output logic [31:0] o_dbus_wdata,
  output logic [3:0]  o_dbus_be,
  input  logic        i_dbus_ack,
  input  logic [31:0] i_dbus_rdata,
  output logic        o_stall,
  output logic        o_wb_wreg,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_misaligned,
  output logic        o_timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;

  logic        in_access;
  logic [1:0]  in_size;
  logic [1:0]  in_off;
  logic        in_mis;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  logic        lat_we;
  logic        lat_wreg;
  logic [4:0]  lat_rd;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic [1:0]  lat_size;
  logic        lat_sext;
  logic        latch_en;

  logic        wb_wreg_nxt;
  logic [4:0]  wb_rd_nxt;
  logic [31:0] wb_data_nxt;
  logic        mis_nxt;
  logic        tmo_nxt;

  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [1:0] off,
                                           input logic [1:0] size, input logic sext);
    logic [31:0] lane;
    lane = rdata >> {off, 3'b000};
    case (size)
      SZ_B:    fmt_load = {{24{sext & lane[7]}}, lane[7:0]};
      SZ_H:    fmt_load = {{16{sext & lane[15]}}, lane[15:0]};
      default: fmt_load = rdata;
    endcase
  endfunction

  always_comb begin
    in_access = i_mem_wmem | i_mem_mem2reg;
    in_off    = i_mem_data[1:0];
    in_size   = i_mem_lsb ? SZ_B : (i_mem_lsh ? SZ_H : SZ_W);
    in_mis    = 1'b0;
    in_be     = 4'b1111;
    in_wdata  = i_mem_dmem;
    case (in_size)
      SZ_B: begin
        in_be    = 4'b0001 << in_off;
        in_wdata = {4{i_mem_dmem[7:0]}};
      end
      SZ_H: begin
        in_be    = in_off[1] ? 4'b1100 : 4'b0011;
        in_wdata = {2{i_mem_dmem[15:0]}};
        in_mis   = in_off[0];
      end
      default: in_mis = (in_off != 2'b00);
    endcase
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    latch_en     = 1'b0;
    o_dbus_req   = 1'b0;
    o_dbus_we    = 1'b0;
    o_dbus_addr  = {i_mem_data[31:2], 2'b00};
    o_dbus_wdata = in_wdata;
    o_dbus_be    = in_be;
    o_stall      = 1'b0;
    wb_wreg_nxt  = 1'b0;
    wb_rd_nxt    = i_mem_rd;
    wb_data_nxt  = i_mem_data;
    mis_nxt      = 1'b0;
    tmo_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (!in_access) begin
          wb_wreg_nxt = i_mem_wreg;
        end else if (in_mis) begin
          mis_nxt = 1'b1;
        end else begin
          o_dbus_req = 1'b1;
          o_dbus_we  = i_mem_wmem;
          if (i_dbus_ack) begin
            if (!i_mem_wmem) begin
              wb_wreg_nxt = i_mem_wreg;
              wb_data_nxt = fmt_load(i_dbus_rdata, in_off, in_size, i_mem_loadsignext);
            end
          end else begin
            o_stall      = 1'b1;
            latch_en     = 1'b1;
            state_nxt    = BUSY;
            wait_cnt_nxt = CW'(1);
          end
        end
      end
      BUSY: begin
        o_dbus_req   = 1'b1;
        o_dbus_we    = lat_we;
        o_dbus_addr  = {lat_addr[31:2], 2'b00};
        o_dbus_wdata = lat_wdata;
        o_dbus_be    = lat_be;
        wb_rd_nxt    = lat_rd;
        if (i_dbus_ack) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
          if (!lat_we) begin
            wb_wreg_nxt = lat_wreg;
            wb_data_nxt = fmt_load(i_dbus_rdata, lat_addr[1:0], lat_size, lat_sext);
          end
        end else if (wait_cnt == CW'(MAX_WAIT)) begin
          // Abort: release the pipeline and the bus; the access is never written back.
          o_dbus_req   = 1'b0;
          tmo_nxt      = 1'b1;
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else begin
          o_stall      = 1'b1;
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (i_reset) begin
      o_dbus_req = 1'b0;
      o_stall    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      o_wb_wreg    <= 1'b0;
      o_wb_rd      <= 5'd0;
      o_wb_data    <= 32'd0;
      o_misaligned <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      o_wb_wreg    <= wb_wreg_nxt;
      o_wb_rd      <= wb_rd_nxt;
      o_wb_data    <= wb_data_nxt;
      o_misaligned <= mis_nxt;
      o_timeout    <= tmo_nxt;
    end
  end

  // Request capture needs no reset: it is only read while BUSY.
  always_ff @(posedge i_clk) begin
    if (latch_en) begin
      lat_we    <= i_mem_wmem;
      lat_wreg  <= i_mem_wreg;
      lat_rd    <= i_mem_rd;
      lat_addr  <= i_mem_data;
      lat_wdata <= in_wdata;
      lat_be    <= in_be;
      lat_size  <= in_size;
      lat_sext  <= i_mem_loadsignext;
    end
  end

endmodule
